// File: rtl/mdu_pkg.sv
// Shared definitions for the HI/LO multiply/divide sequencer: op codes,
// FSM state encoding, iteration count and an operand-magnitude helper.
package mdu_pkg;

  localparam logic [1:0] MDU_MULT  = 2'b00;
  localparam logic [1:0] MDU_MULTU = 2'b01;
  localparam logic [1:0] MDU_DIV   = 2'b10;
  localparam logic [1:0] MDU_DIVU  = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam int unsigned MDU_STEPS = 32;

  // Magnitude of a two's-complement word when neg is set, raw value otherwise.
  function automatic logic [31:0] abs32(input logic [31:0] v, input logic neg);
    return neg ? (32'd0 - v) : v;
  endfunction

endpackage

// File: rtl/mdu_iter.sv
// Single combinational step of the iterative multiply/divide datapath.
// Multiply: acc holds the partial product; in_bit is the current multiplier
// bit. Divide: acc holds {rem, quot}; in_bit is the next dividend bit (MSB
// first), shifted into the remainder.
module mdu_iter (
  input  logic        div_mode,
  input  logic [63:0] acc,
  input  logic [31:0] operand,
  input  logic        in_bit,
  output logic [63:0] acc_next
);

  logic [32:0] sum;
  logic [32:0] rem;
  logic [31:0] diff;

  // One shift-add or shift-compare-subtract step.
  always_comb begin
    sum      = '0;
    rem      = '0;
    diff     = '0;
    acc_next = acc;
    if (!div_mode) begin
      sum      = {1'b0, acc[63:32]} + (in_bit ? {1'b0, operand} : 33'd0);
      acc_next = {sum, acc[31:1]};
    end else begin
      rem  = {acc[63:32], in_bit};
      diff = rem[31:0] - operand;
      if (rem >= {1'b0, operand}) begin
        acc_next = {diff, acc[30:0], 1'b1};
      end else begin
        acc_next = {rem[31:0], acc[30:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/hilo_mdu_ctrl.sv
// HI/LO multiply/divide sequencer: FSM, step counter, sign fix-up and result
// registers around the mdu_iter step datapath.
// Optional feature macro: MDU_FAST_MUL_EN (single-cycle 64-bit multiplier for
// MULT/MULTU; divides keep the iterative path).
module hilo_mdu_ctrl
  import mdu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic [1:0]  op_i,
  input  logic [31:0] opa_i,
  input  logic [31:0] opb_i,
  input  logic        flush_i,
  output logic        stall_req_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        hi_we_o,
  output logic        lo_we_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  logic [1:0]  state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic [31:0] opa_q, opa_d;
  logic [31:0] opb_q, opb_d;
  logic [63:0] acc_q, acc_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        neg_quo_q, neg_quo_d;
  logic        neg_rem_q, neg_rem_d;

  logic        accept;
  logic        in_signed;
  logic        sa, sb;
  logic        iter_bit;
  logic [31:0] iter_operand;
  logic [4:0]  rev_idx;
  logic [63:0] iter_next;

  assign accept    = start_i & ~flush_i;
  assign in_signed = ~op_i[0];
  assign sa        = in_signed & opa_i[31];
  assign sb        = in_signed & opb_i[31];

  // Multiply walks multiplier bits LSB first; divide walks dividend bits MSB first.
  assign rev_idx      = 5'(MDU_STEPS - 1) - cnt_q;
  assign iter_operand = op_q[1] ? opb_q : opa_q;
  assign iter_bit     = op_q[1] ? opa_q[rev_idx] : opb_q[cnt_q];

  mdu_iter u_iter (
    .div_mode (op_q[1]),
    .acc      (acc_q),
    .operand  (iter_operand),
    .in_bit   (iter_bit),
    .acc_next (iter_next)
  );

`ifdef MDU_FAST_MUL_EN
  logic [63:0] prod_s;
  logic [63:0] prod_u;
  assign prod_s = $signed({{32{opa_i[31]}}, opa_i}) * $signed({{32{opb_i[31]}}, opb_i});
  assign prod_u = {32'd0, opa_i} * {32'd0, opb_i};
`endif

  // Next-state logic for the FSM and datapath registers.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          op_d      = op_i;
          opa_d     = abs32(opa_i, sa);
          opb_d     = abs32(opb_i, sb);
          neg_quo_d = sa ^ sb;
          neg_rem_d = sa;
          acc_d     = '0;
          cnt_d     = '0;
          state_d   = ST_CALC;
          if (op_i[1] && (opb_i == 32'd0)) begin
            acc_d   = {opa_i, 32'hFFFF_FFFF};
            state_d = ST_DONE;
          end
`ifdef MDU_FAST_MUL_EN
          else if (!op_i[1]) begin
            acc_d   = in_signed ? prod_s : prod_u;
            state_d = ST_DONE;
          end
`endif
        end
      end
      ST_CALC: begin
        acc_d = iter_next;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'(MDU_STEPS - 1)) begin
          state_d = ST_FIX;
        end
      end
      ST_FIX: begin
        // Iteration ran on magnitudes; restore signs for MULT/DIV only.
        if (!op_q[0]) begin
          if (!op_q[1]) begin
            if (neg_quo_q) acc_d = 64'd0 - acc_q;
          end else begin
            if (neg_quo_q) acc_d[31:0]  = 32'd0 - acc_q[31:0];
            if (neg_rem_q) acc_d[63:32] = 32'd0 - acc_q[63:32];
          end
        end
        state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (flush_i) state_d = ST_IDLE;
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      op_q      <= '0;
      opa_q     <= '0;
      opb_q     <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      opa_q     <= opa_d;
      opb_q     <= opb_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
    end
  end

  // Stall is gated by reset so every output reads 0 while reset is held.
  assign stall_req_o = rst_n & (((state_q == ST_IDLE) & accept) | (state_q == ST_CALC) |
                                (state_q == ST_FIX));
  assign busy_o  = (state_q != ST_IDLE);
  assign done_o  = (state_q == ST_DONE);
  assign hi_we_o = done_o;
  assign lo_we_o = done_o;
  assign hi_o    = acc_q[63:32];
  assign lo_o    = acc_q[31:0];

endmodule
